// File: rtl/mul_div_unit_pkg.sv
// Shared CPU package: M-extension op codes, MDU state encodings,
// iteration count and operand-sign helpers used by MDU and decoder.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } func3_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } mdu_state_e;

  localparam int MDU_ITERS = 32;

  function automatic logic is_div(input func3_e f);
    return f[2];
  endfunction

  function automatic logic rs1_signed(input func3_e f);
    return (f == OP_MULH) || (f == OP_MULHSU) ||
           (f == OP_DIV)  || (f == OP_REM);
  endfunction

  function automatic logic rs2_signed(input func3_e f);
    return (f == OP_MULH) || (f == OP_DIV) ||
           (f == OP_REM);
  endfunction

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        s
  );
    return (s && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// 64-bit iterative datapath: shift-add multiply / restoring divide.
// Ports: clk, rst, load (capture magnitudes), step (one iteration),
//        div_mode, op_a, op_b (unsigned magnitudes), acc (64-bit).
module mdu_core
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        div_mode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [63:0] acc
);

  logic [31:0] op_b_q;
  logic        div_q;
  logic [32:0] add_sum;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic        rem_ge;
  logic [63:0] acc_nxt;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend/quotient bits}.
  always_comb begin
    add_sum = {1'b0, acc[63:32]}
            + {1'b0, (acc[0] ? op_b_q : 32'd0)};
    rem_sh  = acc[63:31];
    rem_ge  = rem_sh >= {1'b0, op_b_q};
    // true difference is below 2^32 whenever rem_ge holds
    rem_sub = rem_sh[31:0] - op_b_q;
    acc_nxt = {add_sum, acc[31:1]};
    if (div_q) begin
      if (rem_ge) acc_nxt = {rem_sub, acc[30:0], 1'b1};
      else        acc_nxt = {rem_sh[31:0], acc[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      op_b_q <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      acc    <= {32'd0, op_a};
      op_b_q <= op_b;
      div_q  <= div_mode;
    end else if (step) begin
      acc    <= acc_nxt;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit: FSM, operand capture, sign fix.
// Ports: CLK, RESET, START, FUNC3, DATA1, DATA2, RD_ADDR, KILL in;
//        RESULT, WB_ADDR, WB_EN, BUSY, DONE out (all registered).
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic [4:0]  RD_ADDR,
  input  logic        KILL,
  output logic [31:0] RESULT,
  output logic [4:0]  WB_ADDR,
  output logic        WB_EN,
  output logic        BUSY,
  output logic        DONE
);

  mdu_state_e  state;
  func3_e      op_in;
  func3_e      op_q;
  logic [5:0]  cnt;
  logic [4:0]  rd_q;
  logic [31:0] a_q;
  logic        neg_q;
  logic        rem_neg_q;
  logic        zero_q;
  logic        a_sgn;
  logic        b_sgn;
  logic        accept;
  logic        step;
  logic [63:0] acc;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fin;

  assign op_in  = func3_e'(FUNC3);
  assign a_sgn  = rs1_signed(op_in) && DATA1[31];
  assign b_sgn  = rs2_signed(op_in) && DATA2[31];
  // KILL wins over START in IDLE
  assign accept = (state == S_IDLE) && START && !KILL;
  assign step   = (state == S_CALC) && !KILL;

  mdu_core u_core (
    .clk      (CLK),
    .rst      (RESET),
    .load     (accept),
    .step     (step),
    .div_mode (is_div(op_in)),
    .op_a     (mag(DATA1, rs1_signed(op_in))),
    .op_b     (mag(DATA2, rs2_signed(op_in))),
    .acc      (acc)
  );

  // Sign correction on the unsigned magnitudes. Signed overflow
  // (-2^31 / -1) falls out naturally: 2^31 negated is 2^31.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[31:0] : acc[31:0];
    rem  = rem_neg_q ? -acc[63:32] : acc[63:32];
    fin  = prod[31:0];
    case (op_q)
      OP_MUL:    fin = prod[31:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  fin = prod[63:32];
      OP_DIV,
      OP_DIVU:   fin = zero_q ? 32'hFFFF_FFFF : quo;
      OP_REM,
      OP_REMU:   fin = zero_q ? a_q : rem;
      default:   fin = prod[31:0];
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      RESULT    <= '0;
      WB_ADDR   <= '0;
      WB_EN     <= 1'b0;
      DONE      <= 1'b0;
      BUSY      <= 1'b0;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      a_q       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      DONE  <= 1'b0;
      WB_EN <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_CALC;
            BUSY      <= 1'b1;
            cnt       <= '0;
            op_q      <= op_in;
            rd_q      <= RD_ADDR;
            a_q       <= DATA1;
            neg_q     <= a_sgn ^ b_sgn;
            rem_neg_q <= a_sgn;
            zero_q    <= (DATA2 == 32'd0);
          end
        end
        S_CALC: begin
          if (KILL) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == 6'(MDU_ITERS - 1)) begin
            state <= S_FINISH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          if (!KILL) begin
            RESULT  <= fin;
            WB_ADDR <= rd_q;
            DONE    <= 1'b1;
            WB_EN   <= (rd_q != 5'd0);
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases,
// randomized ops vs. an arithmetic model, START/KILL/RESET scenarios.
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNC3;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [4:0]  RD_ADDR;
  logic        KILL;
  logic [31:0] RESULT;
  logic [4:0]  WB_ADDR;
  logic        WB_EN;
  logic        BUSY;
  logic        DONE;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mul_div_unit dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .FUNC3   (FUNC3),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .RD_ADDR (RD_ADDR),
    .KILL    (KILL),
    .RESULT  (RESULT),
    .WB_ADDR (WB_ADDR),
    .WB_EN   (WB_EN),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  // RV32M semantics straight from plain 64-bit arithmetic
  function automatic logic [31:0] model(
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic issue(
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd
  );
    @(negedge CLK);
    FUNC3   = f;
    DATA1   = a;
    DATA2   = b;
    RD_ADDR = rd;
    START   = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Cycles from the START edge to DONE; inputs are scrambled meanwhile.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      DATA1   = $urandom;
      DATA2   = $urandom;
      FUNC3   = 3'($urandom);
      RD_ADDR = 5'($urandom);
      if (DONE) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({RESULT, WB_ADDR, WB_EN, DONE, BUSY} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {RESULT, WB_ADDR, WB_EN, DONE, BUSY});
    end
    START = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold_busy got=%b exp=0", BUSY);
    end
    @(negedge CLK);
    START = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic test_directed;
    vec_t v[12];
    int   lat;
    logic [31:0] r;
    v = '{
      '{3'd0, 32'd7,         32'd6,         5'd5,  32'd42},
      '{3'd1, 32'hFFFFFFFE,  32'd3,         5'd6,  32'hFFFFFFFF},
      '{3'd3, 32'hFFFFFFFE,  32'd3,         5'd7,  32'd2},
      '{3'd4, 32'hFFFFFFF9,  32'd2,         5'd8,  32'hFFFFFFFD},
      '{3'd6, 32'hFFFFFFF9,  32'd2,         5'd9,  32'hFFFFFFFF},
      '{3'd5, 32'd100,       32'd0,         5'd10, 32'hFFFFFFFF},
      '{3'd7, 32'd100,       32'd0,         5'd11, 32'd100},
      '{3'd4, 32'h80000000,  32'hFFFFFFFF,  5'd12, 32'h80000000},
      '{3'd6, 32'h80000000,  32'hFFFFFFFF,  5'd13, 32'd0},
      '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd14, 32'hFFFFFFFF},
      '{3'd4, 32'd7,         32'd0,         5'd15, 32'hFFFFFFFF},
      '{3'd6, 32'hFFFFFFFB,  32'd0,         5'd31, 32'hFFFFFFFB}
    };
    for (int i = 0; i < 12; i++) begin
      issue(v[i].f, v[i].a, v[i].b, v[i].rd);
      wait_done(lat);
      checks++;
      if (lat != 33) begin
        failures++;
        $display("FAIL dir%0d_latency got=%0d exp=33", i, lat);
      end
      checks++;
      if (RESULT !== v[i].exp) begin
        failures++;
        $display("FAIL dir%0d_result got=%h exp=%h",
                 i, RESULT, v[i].exp);
      end
      checks++;
      if ({WB_ADDR, WB_EN} !== {v[i].rd, 1'b1}) begin
        failures++;
        $display("FAIL dir%0d_wb got=%h/%b exp=%h/1",
                 i, WB_ADDR, WB_EN, v[i].rd);
      end
      r = RESULT;
      @(negedge CLK);
      checks++;
      if ({DONE, WB_EN, BUSY} !== 3'b000 || RESULT !== r) begin
        failures++;
        $display("FAIL dir%0d_after got=%b%b%b/%h exp=000/%h",
                 i, DONE, WB_EN, BUSY, RESULT, r);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [4:0]  rd;
    logic [31:0] sp[4];
    int          lat;
    sp = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000};
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = sp[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = sp[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      exp = model(f, a, b);
      issue(f, a, b, rd);
      wait_done(lat);
      checks++;
      if (lat != 33 || RESULT !== exp) begin
        failures++;
        $display("FAIL rnd%0d f=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=33",
                 i, f, a, b, RESULT, lat, exp);
      end
      checks++;
      if ({WB_ADDR, WB_EN} !== {rd, (rd != 5'd0)}) begin
        failures++;
        $display("FAIL rnd%0d_wb got=%h/%b exp=%h/%b",
                 i, WB_ADDR, WB_EN, rd, rd != 5'd0);
      end
    end
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    int first = -1;
    issue(3'd0, 32'd3, 32'd5, 5'd7);
    for (int c = 1; c <= 70; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (c == 9) begin
        FUNC3 = 3'd5;
        DATA1 = 32'd1000;
        DATA2 = 32'd3;
        START = 1'b1;
      end
      if (c == 10) START = 1'b0;
      if (DONE) begin
        dones++;
        if (first < 0) first = c;
      end
    end
    checks++;
    if (dones != 1 || first != 33) begin
      failures++;
      $display("FAIL start_ignored dones=%0d at=%0d exp=1 at=33",
               dones, first);
    end
    checks++;
    if (RESULT !== 32'd15) begin
      failures++;
      $display("FAIL start_ignored_result got=%h exp=%h",
               RESULT, 32'd15);
    end
  endtask

  task automatic test_kill;
    int dones = 0;
    issue(3'd4, $urandom, 32'd9, 5'd3);
    for (int c = 1; c <= 60; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (c == 19) begin
        checks++;
        if (BUSY !== 1'b1) begin
          failures++;
          $display("FAIL kill_busy_before got=%b exp=1", BUSY);
        end
        KILL = 1'b1;
      end
      if (c == 20) begin
        KILL = 1'b0;
        checks++;
        if (BUSY !== 1'b0) begin
          failures++;
          $display("FAIL kill_busy_after got=%b exp=0", BUSY);
        end
      end
      if (DONE || WB_EN) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL kill_no_done got=%0d exp=0", dones);
    end
    @(negedge CLK);
    START = 1'b1;
    KILL  = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    KILL  = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL kill_start_idle got=%b exp=0", BUSY);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int stray = 0;
    issue(3'd4, 32'd1000, 32'd7, 5'd9);
    for (int c = 1; c <= 15; c++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({RESULT, WB_ADDR, WB_EN, DONE, BUSY} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h exp=0",
               {RESULT, WB_ADDR, WB_EN, DONE, BUSY});
    end
    @(negedge CLK);
    RESET = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (DONE || BUSY) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_mid_discard got=%0d exp=0", stray);
    end
    issue(3'd0, 32'd9, 32'd9, 5'd0);
    wait_done(lat);
    checks++;
    if (lat != 33 || WB_EN !== 1'b0 || RESULT !== 32'd81) begin
      failures++;
      $display("FAIL rd0_op lat=%0d wb_en=%b res=%h exp=33/0/%h",
               lat, WB_EN, RESULT, 32'd81);
    end
  endtask

  initial begin
    RESET   = 1'b1;
    START   = 1'b0;
    KILL    = 1'b0;
    FUNC3   = 3'd0;
    DATA1   = 32'd0;
    DATA2   = 32'd0;
    RD_ADDR = 5'd0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
